alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named sysclk and rst_n.
REQ-002 Parameter ALU_WIDTH SHALL default to 8 and set the datapath width W (legal range 4..32).
REQ-003 Parameter REG_SRC_W SHALL default to 5 and set the reg_src width.
REQ-004 Parameter A_REG_MAP SHALL default to 16 and is the reg_src code that loads operand A.
REQ-005 Parameter B_REG_MAP SHALL default to 17 and is the reg_src code that loads operand B.
REQ-006 Ports SHALL be as follows; all outputs are registered:
- sysclk  in  1  clock
- rst_n  in  1  async active-low reset
- alu_en  in  1  operand-load enable
- reg_src  in  REG_SRC_W  operand-register select
- A_bus  in  W  operand A data
- B_bus  in  W  operand B data
- op_valid  in  1  operation request
- alu_op  in  4  opcode
- op_ready  out  1  block can accept an operation
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- alu_result  out  W  result
- cc_greater  out  1  A>B (unsigned), set by CMP
- cc_equal  out  1  A==B, set by CMP
- cc_carry  out  1  carry/borrow/overflow flag
- cc_zero  out  1  result == 0

Function
REQ-007 Operand loading: on a sysclk edge with alu_en=1, reg_src==A_REG_MAP loads A_reg<=A_bus and reg_src==B_REG_MAP loads B_reg<=B_bus; this is allowed only in IDLE and is ignored in EXEC/DONE.
REQ-008 FSM states SHALL be IDLE, EXEC, DONE; op_ready=1 only in IDLE; res_valid=1 only in DONE.
REQ-009 An operation is accepted when op_valid && op_ready; the block latches alu_op and goes IDLE->EXEC.
REQ-010 Opcodes SHALL be:
- 0 NOP; 1 ADD; 2 SUB; 3 OR; 4 AND; 5 NOT(A); 6 LSL; 7 LSR; 8 ASR; 9 CMP; 10 MUL
- 11..15 illegal: treated as NOP.
REQ-011 Single-cycle ops (0-5, 9, illegal) SHALL spend exactly one cycle in EXEC, so res_valid rises 2 edges after the accept edge.
REQ-012 Shifts SHALL iterate one bit per cycle: n = min(B_reg, W) iterations, minimum 1 EXEC cycle when n=0; LSL/LSR zero-fill; ASR sign-fills; amounts >= W give 0 (LSL/LSR) or all-sign (ASR).
REQ-013 MUL SHALL be an unsigned shift-add taking exactly W EXEC cycles; alu_result = low W bits of the product; cc_carry = 1 if the high W bits are nonzero.
REQ-014 ADD: cc_carry = carry-out. SUB: cc_carry = borrow (A<B). Other ops leave cc_carry unchanged.
REQ-015 CMP: alu_result=0; cc_greater/cc_equal are updated; all other ops leave cc_greater/cc_equal unchanged.
REQ-016 cc_zero SHALL update on every legal op except CMP, from the final result; NOP and illegal ops produce result 0 and update no flags.
REQ-017 In DONE, result and flags SHALL hold until res_ready=1; that edge returns to IDLE, with op_ready=1 on the following cycle.
REQ-018 op_valid asserted outside IDLE SHALL be ignored (no queueing).
REQ-019 Operand registers SHALL not change during EXEC/DONE, so the result depends only on values latched before accept.

Reset
REQ-020 On rst_n=0, asynchronously: state=IDLE; A_reg, B_reg, alu_result, and all cc_* = 0; res_valid=0; op_ready=1 after reset release.
REQ-021 Reset during EXEC or DONE SHALL abort the operation; no result is delivered.

Structure
REQ-022 Package alu_pkg SHALL hold the opcode enum (alu_op_e, 4 bits) and the FSM state enum (alu_state_e).
REQ-023 The iterative engine SHALL be sub-module alu_iter_engine (start, op, A, B -> busy, done, result, carry), covering the shift and MUL ops.
REQ-024 Single-cycle ops SHALL be combinational logic inside alu_seq_unit.

Verification
REQ-025 W=8: A=200, B=100, ADD -> result 44, cc_carry=1, cc_zero=0, res_valid 2 cycles after accept.
REQ-026 W=8: A=5, B=5, CMP -> cc_equal=1, cc_greater=0, result 0; then A=6 CMP -> cc_greater=1, cc_equal=0.
REQ-027 W=8: A=0x81, B=3, ASR -> 0xF0 after 3 EXEC cycles; B=9 LSL -> 0x00 after 8 EXEC cycles.
REQ-028 W=8: A=20, B=13, MUL -> result 0x04, cc_carry=1, res_valid exactly 9 edges after accept; an A_bus load during EXEC is ignored.
REQ-029 Hold res_ready=0 for 5 cycles in DONE -> result stable, op_ready=0; assert rst_n=0 mid-MUL -> all outputs 0, op_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcode and FSM state encodings shared by the sequential ALU.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_OR  = 4'd3,
        OP_AND = 4'd4,
        OP_NOT = 4'd5,
        OP_LSL = 4'd6,
        OP_LSR = 4'd7,
        OP_ASR = 4'd8,
        OP_CMP = 4'd9,
        OP_MUL = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Opcodes handled by the multi-cycle engine rather than the single-cycle path.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) || (op == OP_MUL);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_iter_engine.sv
`default_nettype none
// ============================================================================
// Module  : alu_iter_engine
// Brief   : Bit-serial shifter and shift-add multiplier, one step per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module alu_iter_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_noshift;
    logic [WIDTH:0]   w_sum;

    // Multiplier keeps the running product in {r_hi, r_lo}; r_lo doubles as the shift value.
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign result = r_lo;
    assign carry  = (r_op == OP_MUL) && (|r_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_noshift <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_op    <= op;
                r_hi    <= '0;
                r_lo    <= a;
                r_mcand <= b;
                busy    <= 1'b1;
                if (op == OP_MUL) begin
                    r_cnt     <= CNT_W'(WIDTH);
                    r_noshift <= 1'b0;
                end else if (b >= WIDTH'(WIDTH)) begin
                    r_cnt     <= CNT_W'(WIDTH);
                    r_noshift <= 1'b0;
                end else if (b == '0) begin
                    // Zero shift still occupies one cycle, but leaves the value alone.
                    r_cnt     <= CNT_W'(1);
                    r_noshift <= 1'b1;
                end else begin
                    r_cnt     <= CNT_W'(b);
                    r_noshift <= 1'b0;
                end
            end else if (busy) begin
                if (!r_noshift) begin
                    case (r_op)
                        OP_LSL:  r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        OP_LSR:  r_lo <= {1'b0, r_lo[WIDTH-1:1]};
                        OP_ASR:  r_lo <= {r_lo[WIDTH-1], r_lo[WIDTH-1:1]};
                        OP_MUL: begin
                            r_hi <= w_sum[WIDTH:1];
                            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
                        end
                        default: r_lo <= r_lo;
                    endcase
                end
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule : alu_iter_engine
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_unit
// Brief   : Sequential ALU with operand registers, condition codes and handshake.
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int ALU_WIDTH = 8,
    parameter int REG_SRC_W = 5,
    parameter int A_REG_MAP = 16,
    parameter int B_REG_MAP = 17
)(
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 alu_en,
    input  logic [REG_SRC_W-1:0] reg_src,
    input  logic [ALU_WIDTH-1:0] A_bus,
    input  logic [ALU_WIDTH-1:0] B_bus,
    input  logic                 op_valid,
    input  logic [3:0]           alu_op,
    output logic                 op_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ALU_WIDTH-1:0] alu_result,
    output logic                 cc_greater,
    output logic                 cc_equal,
    output logic                 cc_carry,
    output logic                 cc_zero
);

    localparam int W = ALU_WIDTH;

    alu_state_e     r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [3:0]     r_op;
    logic           r_is_iter;
    logic           r_tick;

    logic           w_accept;
    logic           w_load_a;
    logic           w_load_b;
    logic           w_fin;
    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_res;
    logic           w_carry;
    logic           w_upd_carry;
    logic           w_upd_zero;
    logic           w_upd_cmp;

    logic           w_eng_busy;
    logic           w_eng_done;
    logic [W-1:0]   w_eng_result;
    logic           w_eng_carry;

    assign w_accept = op_valid && (r_state == ST_IDLE);
    // A load on the accept edge would slip in after the operation has been taken; drop it.
    assign w_load_a = alu_en && (reg_src == REG_SRC_W'(A_REG_MAP)) && (r_state == ST_IDLE) && !w_accept;
    assign w_load_b = alu_en && (reg_src == REG_SRC_W'(B_REG_MAP)) && (r_state == ST_IDLE) && !w_accept;

    // Single-cycle ops finish on the second edge after accept; r_tick marks the first.
    assign w_fin = (r_state == ST_EXEC) &&
                   (r_is_iter ? (w_eng_done && !w_eng_busy) : !r_tick);

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    alu_iter_engine #(
        .WIDTH (W)
    ) u_iter (
        .clk    (sysclk),
        .rst_n  (rst_n),
        .start  (w_accept && is_iter_op(alu_op)),
        .op     (alu_op),
        .a      (r_a),
        .b      (r_b),
        .busy   (w_eng_busy),
        .done   (w_eng_done),
        .result (w_eng_result),
        .carry  (w_eng_carry)
    );

    always_comb begin
        w_res       = '0;
        w_carry     = 1'b0;
        w_upd_carry = 1'b0;
        w_upd_zero  = 1'b0;
        w_upd_cmp   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res       = w_sum[W-1:0];
                w_carry     = w_sum[W];
                w_upd_carry = 1'b1;
                w_upd_zero  = 1'b1;
            end
            OP_SUB: begin
                w_res       = w_diff[W-1:0];
                w_carry     = w_diff[W];
                w_upd_carry = 1'b1;
                w_upd_zero  = 1'b1;
            end
            OP_OR: begin
                w_res      = r_a | r_b;
                w_upd_zero = 1'b1;
            end
            OP_AND: begin
                w_res      = r_a & r_b;
                w_upd_zero = 1'b1;
            end
            OP_NOT: begin
                w_res      = ~r_a;
                w_upd_zero = 1'b1;
            end
            OP_LSL, OP_LSR, OP_ASR: begin
                w_res      = w_eng_result;
                w_upd_zero = 1'b1;
            end
            OP_MUL: begin
                w_res       = w_eng_result;
                w_carry     = w_eng_carry;
                w_upd_carry = 1'b1;
                w_upd_zero  = 1'b1;
            end
            OP_CMP: begin
                w_upd_cmp = 1'b1;
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_is_iter  <= 1'b0;
            r_tick     <= 1'b0;
            op_ready   <= 1'b1;
            res_valid  <= 1'b0;
            alu_result <= '0;
            cc_greater <= 1'b0;
            cc_equal   <= 1'b0;
            cc_carry   <= 1'b0;
            cc_zero    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_load_a) r_a <= A_bus;
            if (w_load_b) r_b <= B_bus;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= alu_op;
                        r_is_iter <= is_iter_op(alu_op);
                        r_tick    <= 1'b1;
                        r_state   <= ST_EXEC;
                        op_ready  <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (w_fin) begin
                        alu_result <= w_res;
                        if (w_upd_carry) cc_carry <= w_carry;
                        if (w_upd_zero)  cc_zero  <= (w_res == '0);
                        if (w_upd_cmp) begin
                            cc_greater <= (r_a > r_b);
                            cc_equal   <= (r_a == r_b);
                        end
                        r_state   <= ST_DONE;
                        res_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state   <= ST_IDLE;
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    res_valid <= 1'b0;
                    op_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule : alu_seq_unit
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq_unit
// Brief   : Directed self-checking bench for alu_seq_unit with a result scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    localparam int W = 8;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
        int         lat;
    } exp_t;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       alu_en = 1'b0;
    logic [4:0] reg_src = '0;
    logic [7:0] A_bus = '0;
    logic [7:0] B_bus = '0;
    logic       op_valid = 1'b0;
    logic [3:0] alu_op = '0;
    logic       op_ready;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] alu_result;
    logic       cc_greater;
    logic       cc_equal;
    logic       cc_carry;
    logic       cc_zero;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic [7:0] ma = '0;
    logic [7:0] mb = '0;
    logic       mg = 1'b0, me = 1'b0, mc = 1'b0, mz = 1'b0;

    alu_seq_unit dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .alu_en     (alu_en),
        .reg_src    (reg_src),
        .A_bus      (A_bus),
        .B_bus      (B_bus),
        .op_valid   (op_valid),
        .alu_op     (alu_op),
        .op_ready   (op_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .alu_result (alu_result),
        .cc_greater (cc_greater),
        .cc_equal   (cc_equal),
        .cc_carry   (cc_carry),
        .cc_zero    (cc_zero)
    );

    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] src, input logic [7:0] a, input logic [7:0] b);
        alu_en  = 1'b1;
        reg_src = src;
        A_bus   = a;
        B_bus   = b;
        step();
        alu_en  = 1'b0;
        if (src == 5'd16) ma = a;
        if (src == 5'd17) mb = b;
    endtask

    task automatic do_op(input logic [3:0] op, input string tag, input int hold, input bit poke);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          sh;
        logic [15:0] p;
        logic [7:0]  keep;
        e.res = '0;
        e.lat = 2;
        sh = (int'(mb) > W) ? W : int'(mb);
        case (op)
            4'd1: begin {mc, e.res} = {1'b0, ma} + {1'b0, mb}; mz = (e.res == 0); end
            4'd2: begin e.res = ma - mb; mc = (ma < mb); mz = (e.res == 0); end
            4'd3: begin e.res = ma | mb; mz = (e.res == 0); end
            4'd4: begin e.res = ma & mb; mz = (e.res == 0); end
            4'd5: begin e.res = ~ma; mz = (e.res == 0); end
            4'd6: begin e.res = ma << sh; mz = (e.res == 0); e.lat = (sh == 0 ? 1 : sh) + 1; end
            4'd7: begin e.res = ma >> sh; mz = (e.res == 0); e.lat = (sh == 0 ? 1 : sh) + 1; end
            4'd8: begin e.res = 8'($signed(ma) >>> sh); mz = (e.res == 0); e.lat = (sh == 0 ? 1 : sh) + 1; end
            4'd9: begin mg = (ma > mb); me = (ma == mb); end
            4'd10: begin
                p = {8'd0, ma} * {8'd0, mb};
                e.res = p[7:0];
                mc = |p[15:8];
                mz = (e.res == 0);
                e.lat = W + 1;
            end
            default: e.res = '0;
        endcase
        e.flags = {mg, me, mc, mz};
        sb.push_back(e);

        op_valid = 1'b1;
        alu_op   = op;
        step();
        op_valid = 1'b0;
        alu_op   = '0;
        chk({tag, " op_ready_exec"}, 32'(op_ready), 32'd0);
        if (poke) begin
            alu_en  = 1'b1;
            reg_src = 5'd16;
            A_bus   = 8'hFF;
        end
        lat = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            step();
            alu_en = 1'b0;
            if (res_valid === 1'b1) lat = k;
        end
        got = sb.pop_front();
        chk({tag, " latency"}, 32'(lat), 32'(got.lat));
        chk({tag, " result"}, 32'(alu_result), 32'(got.res));
        chk({tag, " flags"}, 32'({cc_greater, cc_equal, cc_carry, cc_zero}), 32'(got.flags));
        keep = alu_result;
        for (int h = 0; h < hold; h++) begin
            op_valid = 1'b1;
            alu_op   = 4'd1;
            step();
            chk({tag, " hold_result"}, 32'(alu_result), 32'(keep));
            chk({tag, " hold_ready"}, 32'({op_ready, res_valid}), 32'b01);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, " released"}, 32'({op_ready, res_valid}), 32'b10);
    endtask

    initial begin
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        step();
        step();
        chk("reset outputs", 32'({res_valid, cc_greater, cc_equal, cc_carry, cc_zero, alu_result}), 32'd0);
        rst_n = 1'b1;
        step();
        chk("reset op_ready", 32'(op_ready), 32'd1);

        load(5'd16, 8'd200, 8'd0);
        load(5'd17, 8'd0, 8'd100);
        do_op(4'd1, "add_carry", 0, 1'b0);

        load(5'd16, 8'd5, 8'd0);
        load(5'd17, 8'd0, 8'd5);
        do_op(4'd9, "cmp_equal", 0, 1'b0);
        load(5'd16, 8'd6, 8'd0);
        do_op(4'd9, "cmp_greater", 0, 1'b0);

        load(5'd16, 8'd3, 8'd0);
        do_op(4'd2, "sub_borrow", 0, 1'b0);
        load(5'd17, 8'd0, 8'd3);
        do_op(4'd2, "sub_zero", 0, 1'b0);

        load(5'd16, 8'hA5, 8'd0);
        load(5'd17, 8'd0, 8'h3C);
        do_op(4'd3, "or", 0, 1'b0);
        do_op(4'd4, "and", 0, 1'b0);
        do_op(4'd5, "not", 0, 1'b0);
        do_op(4'd0, "nop", 0, 1'b0);
        do_op(4'd13, "illegal", 0, 1'b0);

        load(5'd16, 8'h81, 8'd0);
        load(5'd17, 8'd0, 8'd3);
        do_op(4'd8, "asr3_hold", 5, 1'b0);
        load(5'd17, 8'd9, 8'd9);
        do_op(4'd6, "lsl9", 0, 1'b0);
        load(5'd17, 8'd0, 8'd0);
        do_op(4'd7, "lsr0", 0, 1'b0);

        load(5'd16, 8'd20, 8'd0);
        load(5'd17, 8'd0, 8'd13);
        do_op(4'd10, "mul_poke", 0, 1'b1);
        do_op(4'd5, "not_after_poke", 0, 1'b0);

        // Abort a multiply part-way through with reset.
        op_valid = 1'b1;
        alu_op   = 4'd10;
        step();
        op_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort outputs", 32'({res_valid, cc_greater, cc_equal, cc_carry, cc_zero, alu_result}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("abort op_ready", 32'({op_ready, res_valid}), 32'b10);
        for (int k = 0; k < 12; k++) step();
        chk("abort no_result", 32'({op_ready, res_valid}), 32'b10);
        ma = '0; mb = '0; mg = 1'b0; me = 1'b0; mc = 1'b0; mz = 1'b0;
        do_op(4'd1, "add_after_reset", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_seq_unit
`default_nettype wire
